// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-locked round-robin arbiter sharing one fifo write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 16,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     fifo_full_i,
  output logic                     w_valid_o,
  output logic [WIDTH-1:0]         data_in_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [IW-1:0]            owner_id_o,
  output logic                     locked_o,
  output logic [CNT_WIDTH-1:0]     xfer_cnt_o
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d, rr_q, rr_d, sel;
  logic [BW-1:0]        burst_q, burst_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW:0]          scan;
  logic                 sel_vld, go;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return x == IW'(NUM_REQ - 1) ? '0 : x + IW'(1);
  endfunction

  // Descending scan so the port closest to rr_q (lowest offset) wins.
  always_comb begin
    sel = owner_q;
    sel_vld = rst_n & req_valid_i[owner_q];
    scan = '0;
    if (state_q == IDLE) begin
      sel_vld = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        scan = {1'b0, rr_q} + (IW+1)'(i);
        scan = scan >= (IW+1)'(NUM_REQ) ? scan - (IW+1)'(NUM_REQ) : scan;
        if (req_valid_i[scan[IW-1:0]]) begin
          sel = scan[IW-1:0];
          sel_vld = rst_n;
        end
      end
    end
  end

  assign go = sel_vld & arb_en_i & ~fifo_full_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  // An owner dropping valid releases the lock without granting anyone that cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    cnt_d   = go ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    if (state_q == IDLE) begin
      if (go) begin
        owner_d = sel;
        burst_d = BW'(1);
        if (MAX_BURST == 1) rr_d = wrap_inc(sel);
        else state_d = BURST;
      end
    end else if (!req_valid_i[owner_q] || (go && burst_q + BW'(1) == BW'(MAX_BURST))) begin
      state_d = IDLE;
      burst_d = '0;
      rr_d    = wrap_inc(owner_q);
    end else if (go) begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    data_in_o   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_o[k]     = sel_vld & arb_en_i & (sel == IW'(k));
      req_ready_o[k] = go & (sel == IW'(k));
      data_in_o      = (sel_vld && sel == IW'(k)) ? req_data_i[k*WIDTH +: WIDTH] : data_in_o;
    end
  end

  assign w_valid_o  = go;
  assign owner_id_o = owner_q;
  assign locked_o   = state_q == BURST;
  assign xfer_cnt_o = cnt_q;
endmodule
